// File: rtl/core_pkg.sv
// Shared core constants: controller phase encodings, fetch FSM states and
// datapath width. Decode and the core controller import the same package.
package core_pkg;

    localparam int XLEN = 32;

    // Core controller phase encodings, driven on the 3-bit state bus
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    // jalr clears bit 0 of the computed target
    localparam logic [XLEN-1:0] JALR_MASK = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_DONE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC computation: taken decision, branch/jump target and misalignment
// flag. Purely combinational so a future branch predictor can reuse it.
module pc_next_calc
    import core_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic            branch_uc_i,
    input  logic            branch_c_i,
    input  logic            branch_relative_i,
    input  logic            cond_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            taken_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] target;

    // Target select and taken/misalign decision; all arithmetic wraps mod 2^32
    always_comb begin
        target     = branch_relative_i ? (pc_i + imm_i)
                                       : ((rs1_data_i + imm_i) & JALR_MASK);
        taken_o    = branch_uc_i | (branch_c_i & cond_i);
        next_pc_o  = taken_o ? target : (pc_i + 32'd4);
        misalign_o = taken_o & target[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request per FETCH
// phase, holds the fetched word for decode and commits the next PC in WRITE.
//
// state  | meaning
// -------+---------------------------------------------------------------
// F_IDLE | no request outstanding; waits for the controller to enter FETCH
// F_REQ  | first request cycle, imem_req high, zero-wait response accepted
// F_WAIT | request held, each cycle counted as a stall
// F_DONE | word latched, fetch_done pulsed on entry; parked until FETCH ends
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             state_i,
    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic                   imem_valid_i,
    input  logic [XLEN-1:0]        imem_rdata_i,
    output logic [XLEN-1:0]        instr_raw_o,
    output logic                   fetch_done_o,
    output logic [XLEN-1:0]        pc_o,
    output logic [XLEN-1:0]        pc_plus4_o,
    input  logic                   pc_update_i,
    input  logic                   branch_uc_i,
    input  logic                   branch_c_i,
    input  logic                   branch_relative_i,
    input  logic [XLEN-1:0]        imm_i,
    input  logic [XLEN-1:0]        rs1_data_i,
    input  logic [XLEN-1:0]        alu_result_i,
    output logic                   misalign_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    fetch_state_e             state_q, state_d;
    logic [XLEN-1:0]          pc_q, pc_d;
    logic [XLEN-1:0]          instr_q, instr_d;
    logic                     req_q, req_d;
    logic                     done_q, done_d;
    logic                     misalign_q, misalign_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;

    logic [XLEN-1:0]          calc_next_pc;
    logic                     calc_taken;
    logic                     calc_misalign;
    logic                     update_ok;

    // Only bit 0 of the ALU result carries the branch condition
    logic                     unused_alu_bits;
    assign unused_alu_bits = ^alu_result_i[XLEN-1:1];

    pc_next_calc u_pc_next_calc (
        .pc_i              (pc_q),
        .imm_i             (imm_i),
        .rs1_data_i        (rs1_data_i),
        .branch_uc_i       (branch_uc_i),
        .branch_c_i        (branch_c_i),
        .branch_relative_i (branch_relative_i),
        .cond_i            (alu_result_i[0]),
        .next_pc_o         (calc_next_pc),
        .taken_o           (calc_taken),
        .misalign_o        (calc_misalign)
    );

    // Next-state, fetch datapath and PC commit logic
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        stall_d    = stall_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        case (state_q)
            F_IDLE: if (state_i == ST_FETCH) state_d = F_REQ;
            F_REQ:  state_d = imem_valid_i ? F_DONE : F_WAIT;
            F_WAIT: if (imem_valid_i) state_d = F_DONE;
            F_DONE: if (state_i != ST_FETCH) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase

        if ((state_q == F_REQ || state_q == F_WAIT) && imem_valid_i) begin
            instr_d = imem_rdata_i;
        end

        if (state_q == F_WAIT && stall_q != {STALL_CNT_W{1'b1}}) begin
            stall_d = stall_q + 1'b1;
        end

        // Committing a new PC under an outstanding request would change
        // imem_addr mid-transaction, so such an update is dropped.
        update_ok = pc_update_i & ~req_q;
        if (update_ok) begin
            pc_d       = calc_next_pc;
            misalign_d = misalign_q | calc_misalign;
        end

        req_d  = (state_d == F_REQ) || (state_d == F_WAIT);
        done_d = (state_d == F_DONE) && (state_q != F_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= F_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            stall_q    <= stall_d;
        end
    end

    assign imem_req_o     = req_q;
    assign imem_addr_o    = pc_q;
    assign instr_raw_o    = instr_q;
    assign fetch_done_o   = done_q;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_q + 32'd4;
    assign misalign_o     = misalign_q;
    assign stall_cycles_o = stall_q;

endmodule
